// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state encoding, opcode values and legality check for the accumulator CPU sequencer.
package cpu_pkg;
    typedef enum logic [1:0] {ST_FETCH, ST_EXEC1, ST_EXEC2, ST_HALT} state_t;
    localparam logic [3:0] OP_LDA  = 4'd0;
    localparam logic [3:0] OP_LDI  = 4'd1;
    localparam logic [3:0] OP_JMP  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_JEQ  = 4'd6;
    localparam logic [3:0] OP_STA  = 4'd8;
    localparam logic [3:0] OP_JMI  = 4'd10;
    localparam logic [3:0] OP_SUB  = 4'd12;
    localparam logic [3:0] OP_HALT = 4'd15;
    function automatic logic is_legal(input logic [3:0] opc);
        return opc inside {OP_LDA, OP_LDI, OP_JMP, OP_ADD, OP_JEQ, OP_STA, OP_JMI, OP_SUB};
    endfunction
endpackage

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: FETCH/EXEC1/EXEC2/HALT phase sequencer with IR latch, status flags and retire counter.
// Define CPU_SEQ_STEP_EN to add a STEP input that single-steps one instruction while RUN=0.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CNT_W = 16,
    parameter logic [3:0] HALT_OPC = 4'hF
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              RUN,
`ifdef CPU_SEQ_STEP_EN
    input  logic              STEP,
`endif
    input  logic [DATA_W-1:0] MEM_Q,
    input  logic [DATA_W-1:0] ACC_Q,
    input  logic              EXTRA,
    output logic              FTECH,
    output logic              EXEC1,
    output logic              EXEC2,
    output logic [3:0]        IR,
    output logic [DATA_W-5:0] OPERAND,
    output logic              EQ,
    output logic              MI,
    output logic              HALTED,
    output logic              ILLEGAL,
    output logic [CNT_W-1:0]  INSTR_CNT
);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    state_t            r_state;
    logic [3:0]        r_ir;
    logic [DATA_W-5:0] r_operand;
    logic              r_eq, r_mi, r_illegal;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_go;
`ifdef CPU_SEQ_STEP_EN
    assign w_go = RUN | STEP;
`else
    assign w_go = RUN;
`endif
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= ST_FETCH;
            r_ir      <= '0;
            r_operand <= '0;
            r_eq      <= 1'b1;
            r_mi      <= 1'b0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
        end else if (r_state != ST_HALT) begin
            r_eq <= (ACC_Q == '0);
            r_mi <= ACC_Q[DATA_W-1];
            case (r_state)
                ST_FETCH: if (w_go) begin
                    r_ir      <= MEM_Q[DATA_W-1:DATA_W-4];
                    r_operand <= MEM_Q[DATA_W-5:0];
                    r_state   <= ST_EXEC1;
                end
                ST_EXEC1: if (r_ir == HALT_OPC) begin
                    r_state <= ST_HALT;
                end else if (!is_legal(r_ir)) begin
                    r_state   <= ST_HALT;
                    r_illegal <= 1'b1;
                end else if (EXTRA) begin
                    r_state <= ST_EXEC2;
                end else begin
                    r_state <= ST_FETCH;
                    r_cnt   <= r_cnt + CNT_ONE;
                end
                default: begin
                    r_state <= ST_FETCH;
                    r_cnt   <= r_cnt + CNT_ONE;
                end
            endcase
        end
    end
    assign FTECH     = r_state == ST_FETCH;
    assign EXEC1     = r_state == ST_EXEC1;
    assign EXEC2     = r_state == ST_EXEC2;
    assign HALTED    = r_state == ST_HALT;
    assign IR        = r_ir;
    assign OPERAND   = r_operand;
    assign EQ        = r_eq;
    assign MI        = r_mi;
    assign ILLEGAL   = r_illegal;
    assign INSTR_CNT = r_cnt;
endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Instruction-cycle sequencer that sits directly upstream of the instruction decoder in the accumulator CPU. It runs the FETCH/EXEC1/EXEC2 phase state machine and latches the instruction register from program memory. It registers the EQ/MI status flags from the accumulator. Its one-hot phase outputs, opcode and flags feed the decoder directly, and it consumes the decoder's EXTRA output to choose a one- or two-cycle execute.

Parameters:
DATA_W, 16, memory/accumulator word width; opcode = MEM_Q[DATA_W-1:DATA_W-4], operand = MEM_Q[DATA_W-5:0]
CNT_W, 16, width of retired-instruction counter
HALT_OPC, 4'hF, opcode that stops the sequencer

Ports:
CLK  in  1  system clock, rising edge
RESET_N  in  1  asynchronous active-low reset
RUN  in  1  run enable; sampled only in FETCH
MEM_Q  in  DATA_W  program memory read data, valid during FETCH
ACC_Q  in  DATA_W  accumulator value
EXTRA  in  1  from decoder: instruction needs EXEC2
FTECH  out  1  fetch phase (one-hot; spelling matches decoder input)
EXEC1  out  1  execute phase 1
EXEC2  out  1  execute phase 2
IR  out  4  registered opcode
OPERAND  out  DATA_W-4  registered operand field
EQ  out  1  registered ACC==0
MI  out  1  registered ACC sign bit
HALTED  out  1  sequencer in HALT state
ILLEGAL  out  1  sticky: halted on undefined opcode
INSTR_CNT  out  CNT_W  retired-instruction count

Behaviour:
- States: FETCH, EXEC1, EXEC2, HALT. FTECH/EXEC1/EXEC2 decode the state combinationally and are one-hot. All three are 0 in HALT.
- Reset values: state=FETCH (FTECH=1), IR=0, OPERAND=0, EQ=1, MI=0, HALTED=0, ILLEGAL=0, INSTR_CNT=0. Reset is asynchronous, so assertion mid-instruction aborts it immediately.
- FETCH:
  - RUN=1: IR/OPERAND <= MEM_Q fields; go to EXEC1.
  - RUN=0: hold FETCH; IR does not change.
- EXEC1, priority order:
  1. IR==HALT_OPC -> HALT.
  2. IR not in legal set {0,1,2,4,6,8,10,12} -> HALT and set ILLEGAL.
  3. EXTRA=1 -> EXEC2.
  4. Otherwise -> FETCH.
- EXEC2: unconditionally -> FETCH.
- HALT: absorbing; only RESET_N leaves it. HALTED=1.
- RUN deasserted during EXEC1/EXEC2: the current instruction completes, and the sequencer then waits in FETCH.
- INSTR_CNT:
  - Increments by 1 on each EXEC1->FETCH or EXEC2->FETCH transition.
  - Wraps from all-ones to 0.
  - Does not count HALT or illegal opcodes.
- Flags:
  - Every edge while not in HALT: EQ <= (ACC_Q==0) and MI <= ACC_Q[DATA_W-1].
  - Frozen in HALT.
  - The flags carry one cycle of latency. An ACC update in EXEC2 is therefore visible by the next EXEC1, because a FETCH cycle intervenes.
- Latency: 2 cycles per single-execute instruction, 3 per EXTRA instruction.

Optional Feature:
CPU_SEQ_STEP_EN:
- Defined: adds input port STEP (1 bit). While in FETCH with RUN=0, a cycle with STEP=1 fetches exactly one instruction. STEP is level-sampled in FETCH only, and the bench drives it as a single-cycle pulse. With RUN=1, STEP is ignored.
- Undefined: no STEP port; only RUN advances FETCH.

Decomposition:
- Package cpu_pkg holds:
  - state enum (FETCH, EXEC1, EXEC2, HALT)
  - opcode localparams: LDA=0, STA=8, ADD=4, SUB=12, JMP=2, JMI=10, JEQ=6, LDI=1, HALT=15
  - legal-opcode check function
- No sub-module: a single flat module. The flag register and counter are too small to split out.

Test Plan:
- Reset with RUN=1, MEM_Q=16'h1005 (LDI 5), EXTRA=0 -> FTECH, EXEC1, FTECH on successive cycles; IR=1, OPERAND=12'h005, INSTR_CNT=1.
- MEM_Q=16'h0020 (LDA), EXTRA=1 in EXEC1 -> FTECH, EXEC1, EXEC2, FTECH; INSTR_CNT increments only once.
- ACC_Q=16'h8000, then 16'h0000 -> MI=1 EQ=0 one edge later, then EQ=1 MI=0; flags frozen after HALT.
- MEM_Q=16'hF000 -> HALT after EXEC1, HALTED=1, all phases 0, INSTR_CNT unchanged. MEM_Q=16'h3000 -> HALT with ILLEGAL=1.
- RUN dropped during EXEC2 -> returns to FETCH and holds with IR stable; RUN=1 resumes. With CPU_SEQ_STEP_EN, a one-cycle STEP pulse executes exactly one instruction.
- RESET_N low during EXEC2 of an ADD -> immediate FETCH=1, IR=0, counter=0, without waiting for a clock edge.
